mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: WAIT cycles without mem_rvalid before a bus error; the legal range is 2..255.
REQ-002 Parameter FIXED_PRIO, default 0: 0 selects round-robin, 1 makes port B always win.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 a_req  in  1  port A (instruction fetch) request; held until a_gnt or dropped.
REQ-006 a_addr  in  32  port A address; stable while a_req is high.
REQ-007 a_gnt / a_rvalid / a_err  out  1 each  port A accept / read-data-valid / bus-error pulses.
REQ-008 b_req  in  1  port B (load/store) request.
REQ-009 b_addr  in  32  port B address.
REQ-010 b_we  in  1  port B write enable.
REQ-011 b_wdata  in  32  port B write data.
REQ-012 b_gnt / b_rvalid / b_err  out  1 each  port B accept / response / bus-error pulses.
REQ-013 rdata  out  32  shared response data; equals mem_rdata.
REQ-014 mem_req / mem_we  out  1  memory request and write enable.
REQ-015 mem_addr / mem_wdata  out  32  memory address and write data.
REQ-016 mem_gnt / mem_rvalid  in  1  memory accept and response valid.
REQ-017 mem_rdata  in  32  memory read data.
REQ-018 sel  out  1  owner select driving the 2:1 address/data mux: 0 = A, 1 = B.
REQ-019 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-021 IDLE:
  - A rising edge with any req high latches the winner into the owner register (sel) and moves to ISSUE.
  - No req high: remain in IDLE with sel unchanged.
REQ-022 Arbitration with FIXED_PRIO=0:
  - A single requester always wins.
  - Simultaneous requests: the port not served last wins.
  - After reset, "last served" = B, so A wins the first tie.
REQ-023 Arbitration with FIXED_PRIO=1: B wins every tie.
REQ-024 ISSUE, memory signals:
  - mem_req = owner's req.
  - mem_addr = owner's addr, selected via sel.
  - mem_we = b_we if owner is B, else 0.
  - mem_wdata = b_wdata if owner is B, else 0.
REQ-025 ISSUE, accept: mem_gnt=1 with mem_req=1 pulses the owner's gnt combinationally that cycle and moves to WAIT with the timer cleared.
REQ-026 ISSUE, drop: if the owner's req is low, mem_req=0, no gnt is issued, and the FSM returns to IDLE next edge (abort).
REQ-027 WAIT, request outputs: mem_req=0, and mem_addr/mem_we/mem_wdata are driven 0.
REQ-028 WAIT, response: mem_rvalid=1 pulses the owner's rvalid combinationally, rdata=mem_rdata, "last served" is updated to owner, and the FSM returns to IDLE.
REQ-029 WAIT, timer: increments every WAIT cycle without mem_rvalid; its width is $clog2(TIMEOUT_CYC+1).
REQ-030 WAIT, timeout: in the WAIT cycle where timer = TIMEOUT_CYC-1 and mem_rvalid=0, pulse the owner's err for one cycle, update "last served", and return to IDLE.
REQ-031 mem_rvalid and timeout in the same cycle: the response wins and err is not asserted.
REQ-032 mem_rvalid while in IDLE or ISSUE SHALL be ignored, with no rvalid pulse.
REQ-033 mem_gnt outside ISSUE SHALL be ignored.
REQ-034 The non-owner port's gnt/rvalid/err SHALL stay 0 throughout a transaction; its req is held pending and not lost.
REQ-035 Throughput: one transaction per at least 3 cycles (IDLE, ISSUE, WAIT); one IDLE cycle between back-to-back transactions.

Reset
REQ-036 rst_n low SHALL immediately force:
  - state = IDLE, sel = 0, "last served" = B, timer = 0;
  - every gnt/rvalid/err, mem_req, mem_we and busy = 0;
  - mem_addr = mem_wdata = 0.
REQ-037 Reset during ISSUE or WAIT SHALL abandon the transaction; a late mem_rvalid after reset release SHALL be ignored.

Verification
REQ-038 a_req=1, a_addr=0x100, memory: gnt immediate, rvalid 2 cycles later, rdata=0xDEADBEEF -> mem_addr=0x100, a_gnt one cycle, then a_rvalid with rdata=0xDEADBEEF; b outputs 0.
REQ-039 a_req and b_req both held continuously, FIXED_PRIO=0 -> grants alternate A, B, A, B; with FIXED_PRIO=1 -> B every time until b_req drops.
REQ-040 b write, b_addr=0x2000, b_wdata=0x12345678, b_we=1 -> sel=1, mem_we=1, mem_wdata=0x12345678 in ISSUE; b_gnt on mem_gnt.
REQ-041 Memory never asserts rvalid, TIMEOUT_CYC=16 -> owner err pulses in the 16th WAIT cycle, FSM in IDLE next; rvalid in that same cycle -> rvalid, no err.
REQ-042 Owner drops req in ISSUE before mem_gnt -> no gnt, IDLE next cycle; rst_n pulsed low in WAIT -> all outputs 0 at once, later mem_rvalid produces no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch A, load/store B) arbiter onto a single memory port.
// Round-robin or fixed B priority, with a response timeout that raises a bus error.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [31:0] a_addr,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic        a_err,
    input  logic        b_req,
    input  logic [31:0] b_addr,
    input  logic        b_we,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic        b_err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        sel,
    output logic        busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic          last;      // 1 = B was served last
    logic [TW-1:0] timer;
    logic          owner_req;
    logic          win_b;
    logic          in_issue;
    logic          accept;
    logic          resp;
    logic          tout;

    assign owner_req = sel ? b_req : a_req;
    assign in_issue  = (state == ISSUE);
    assign accept    = in_issue && owner_req && mem_gnt;
    assign resp      = (state == WAIT) && mem_rvalid;
    assign tout      = (state == WAIT) && !mem_rvalid && (timer == TLAST);

    always_comb begin
        win_b = b_req;
        if (a_req && b_req)
            win_b = FIXED_PRIO ? 1'b1 : !last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 1'b0;
            last  <= 1'b1;
            timer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        sel   <= win_b;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!owner_req) begin
                        state <= IDLE;
                    end else if (mem_gnt) begin
                        state <= WAIT;
                        timer <= '0;
                    end
                end
                WAIT: begin
                    if (resp || tout) begin
                        last  <= sel;
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a_gnt     = accept && !sel;
    assign b_gnt     = accept && sel;
    assign a_rvalid  = resp && !sel;
    assign b_rvalid  = resp && sel;
    assign a_err     = tout && !sel;
    assign b_err     = tout && sel;
    assign rdata     = mem_rdata;
    assign mem_req   = in_issue && owner_req;
    assign mem_we    = in_issue && sel && b_we;
    assign mem_addr  = in_issue ? (sel ? b_addr : a_addr) : '0;
    assign mem_wdata = (in_issue && sel) ? b_wdata : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle vector table plus timeout,
// reset-in-WAIT and arbitration-order sequences on round-robin and fixed-priority instances.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] a_addr = 32'h100, b_addr = 32'h2000, b_wdata = 32'h12345678;
    logic [31:0] mem_rdata = 32'hDEADBEEF;

    logic        d0_a_gnt, d0_a_rvalid, d0_a_err, d0_b_gnt, d0_b_rvalid, d0_b_err;
    logic        d0_mem_req, d0_mem_we, d0_sel, d0_busy;
    logic [31:0] d0_rdata, d0_mem_addr, d0_mem_wdata;
    logic        d1_a_gnt, d1_a_rvalid, d1_a_err, d1_b_gnt, d1_b_rvalid, d1_b_err;
    logic        d1_mem_req, d1_mem_we, d1_sel, d1_busy;
    logic [31:0] d1_rdata, d1_mem_addr, d1_mem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYC(16), .FIXED_PRIO(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(d0_a_gnt), .a_rvalid(d0_a_rvalid), .a_err(d0_a_err),
        .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
        .b_gnt(d0_b_gnt), .b_rvalid(d0_b_rvalid), .b_err(d0_b_err),
        .rdata(d0_rdata), .mem_req(d0_mem_req), .mem_we(d0_mem_we),
        .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .sel(d0_sel), .busy(d0_busy)
    );

    mem_port_arbiter #(.TIMEOUT_CYC(16), .FIXED_PRIO(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(d1_a_gnt), .a_rvalid(d1_a_rvalid), .a_err(d1_a_err),
        .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
        .b_gnt(d1_b_gnt), .b_rvalid(d1_b_rvalid), .b_err(d1_b_err),
        .rdata(d1_rdata), .mem_req(d1_mem_req), .mem_we(d1_mem_we),
        .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .sel(d1_sel), .busy(d1_busy)
    );

    // {a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, mem_req, mem_we, sel, busy}
    logic [9:0] o0;
    assign o0 = {d0_a_gnt, d0_a_rvalid, d0_a_err, d0_b_gnt, d0_b_rvalid, d0_b_err,
                 d0_mem_req, d0_mem_we, d0_sel, d0_busy};

    typedef struct {
        logic        rst_n, a_req, b_req, b_we, gnt, rvalid;
        logic [9:0]  exp;
        logic [31:0] exp_addr, exp_wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic a, input logic b, input logic we,
                       input logic g, input logic rv, input logic [9:0] e,
                       input logic [31:0] ad, input logic [31:0] wd);
        vec_t v;
        v.rst_n = r; v.a_req = a; v.b_req = b; v.b_we = we; v.gnt = g; v.rvalid = rv;
        v.exp = e; v.exp_addr = ad; v.exp_wdata = wd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    // Brings dut0 into its first WAIT cycle as owner A; returns at posedge+1.
    task automatic enter_wait_a();
        a_req = 1'b1;
        next_cycle();
        mem_gnt = 1'b1;
        next_cycle();
        mem_gnt = 1'b0; a_req = 1'b0;
    endtask

    initial begin
        int ga0, gb0, ga1, gb1;
        logic [3:0] ord0, ord1;

        add(0, 0, 0, 0, 0, 0, 10'b0000000000, 32'h0,    32'h0);        // reset
        add(1, 1, 0, 0, 0, 0, 10'b0000000000, 32'h0,    32'h0);        // IDLE, A requests
        add(1, 1, 0, 0, 1, 0, 10'b1000001001, 32'h100,  32'h0);        // ISSUE A, accept
        add(1, 0, 0, 0, 0, 0, 10'b0000000001, 32'h0,    32'h0);        // WAIT
        add(1, 0, 0, 0, 0, 1, 10'b0100000001, 32'h0,    32'h0);        // WAIT, response
        add(1, 0, 0, 0, 0, 0, 10'b0000000000, 32'h0,    32'h0);        // IDLE
        add(1, 0, 1, 1, 0, 0, 10'b0000000000, 32'h0,    32'h0);        // IDLE, B write
        add(1, 0, 1, 1, 0, 0, 10'b0000001111, 32'h2000, 32'h12345678); // ISSUE B stalled
        add(1, 0, 1, 1, 1, 0, 10'b0001001111, 32'h2000, 32'h12345678); // ISSUE B accept
        add(1, 0, 0, 0, 0, 1, 10'b0000100011, 32'h0,    32'h0);        // WAIT B response
        add(1, 0, 0, 0, 0, 0, 10'b0000000010, 32'h0,    32'h0);        // IDLE keeps sel
        add(1, 1, 0, 0, 0, 0, 10'b0000000010, 32'h0,    32'h0);        // IDLE, A requests
        add(1, 0, 0, 0, 1, 0, 10'b0000000001, 32'h100,  32'h0);        // ISSUE drop: no gnt
        add(1, 0, 0, 0, 1, 1, 10'b0000000000, 32'h0,    32'h0);        // IDLE ignores gnt/rvalid
        add(1, 1, 1, 1, 0, 0, 10'b0000000000, 32'h0,    32'h0);        // tie, last = B
        add(1, 1, 1, 1, 1, 1, 10'b1000001001, 32'h100,  32'h0);        // A wins, rvalid ignored
        add(1, 1, 1, 1, 0, 1, 10'b0100000001, 32'h0,    32'h0);        // WAIT A response
        add(1, 1, 1, 1, 0, 0, 10'b0000000000, 32'h0,    32'h0);        // IDLE, tie again
        add(1, 1, 1, 1, 1, 0, 10'b0001001111, 32'h2000, 32'h12345678); // B wins
        add(1, 0, 0, 0, 0, 1, 10'b0000100011, 32'h0,    32'h0);        // WAIT B response
        add(1, 0, 0, 0, 0, 0, 10'b0000000010, 32'h0,    32'h0);        // IDLE

        next_cycle();
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; a_req = vecs[i].a_req; b_req = vecs[i].b_req;
            b_we = vecs[i].b_we; mem_gnt = vecs[i].gnt; mem_rvalid = vecs[i].rvalid;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i), {22'b0, o0}, {22'b0, vecs[i].exp});
            check($sformatf("vec%0d_addr", i), d0_mem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_wdata", i), d0_mem_wdata, vecs[i].exp_wdata);
            check($sformatf("vec%0d_rdata", i), d0_rdata, 32'hDEADBEEF);
            next_cycle();
        end

        // Timeout: err in the 16th WAIT cycle, IDLE afterwards.
        do_reset();
        enter_wait_a();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("tout_err_c%0d", k), {31'b0, d0_a_err}, {31'b0, (k == 16)});
            check($sformatf("tout_busy_c%0d", k), {31'b0, d0_busy}, 32'd1);
            next_cycle();
        end
        @(negedge clk);
        check("tout_idle", {22'b0, o0}, 32'd0);

        // Response in the timeout cycle wins over err.
        do_reset();
        enter_wait_a();
        for (int k = 1; k <= 16; k++) begin
            mem_rvalid = (k == 16);
            @(negedge clk);
            if (k == 16) begin
                check("race_rvalid", {31'b0, d0_a_rvalid}, 32'd1);
                check("race_err", {31'b0, d0_a_err}, 32'd0);
            end
            next_cycle();
        end
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("race_idle", {31'b0, d0_busy}, 32'd0);

        // Reset asserted mid-WAIT, then a late response.
        do_reset();
        enter_wait_a();
        check("rstw_busy_before", {31'b0, d0_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_outs", {22'b0, o0}, 32'd0);
        check("rstw_addr", d0_mem_addr, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        @(negedge clk);
        check("rstw_late_rvalid", {22'b0, o0}, 32'd0);
        next_cycle();
        mem_rvalid = 1'b0;

        // Continuous tie: dut0 alternates A,B,A,B; dut1 always B until b_req drops.
        do_reset();
        a_req = 1'b1; b_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        ga0 = 0; gb0 = 0; ga1 = 0; gb1 = 0; ord0 = '0; ord1 = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (d0_a_gnt || d0_b_gnt) begin
                if (ga0 + gb0 < 4) ord0[ga0 + gb0] = d0_b_gnt;
                if (d0_a_gnt) ga0++; else gb0++;
            end
            if (d1_a_gnt || d1_b_gnt) begin
                if (ga1 + gb1 < 4) ord1[ga1 + gb1] = d1_b_gnt;
                if (d1_a_gnt) ga1++; else gb1++;
            end
            next_cycle();
        end
        check("rr_count", ga0 + gb0, 32'd4);
        check("rr_order", {28'b0, ord0}, 32'b1010);
        check("fp_count", ga1 + gb1, 32'd4);
        check("fp_order", {28'b0, ord1}, 32'b1111);
        b_req = 1'b0;
        ga1 = 0; gb1 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d1_a_gnt) ga1++;
            if (d1_b_gnt) gb1++;
            next_cycle();
        end
        check("fp_a_after_drop", ga1, 32'd2);
        check("fp_b_after_drop", gb1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
